mem_arbiter: RTL and testbench

//  Shares the single-port RAM between instruction fetch (IF) and the data path (MEM, via cache).

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the RAM arbiter: FSM state codes, chip/write
// enable levels and requester identifiers used by the round-robin option.
package mem_arbiter_pkg;

   // FSM state codes (2-bit, legacy-compatible encoding)
   localparam logic [1:0] ARB_IDLE      = 2'b00;
   localparam logic [1:0] ARB_GRANT_IF  = 2'b01;
   localparam logic [1:0] ARB_GRANT_MEM = 2'b10;

   // RAM strobe levels
   localparam logic CHIP_ENABLE   = 1'b1;
   localparam logic CHIP_DISABLE  = 1'b0;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   // Instruction fetch always reads full words
   localparam logic [3:0] SEL_ALL = 4'b1111;

   // Requester identifiers held in the round-robin last_grant register
   localparam logic GNT_IF  = 1'b0;
   localparam logic GNT_MEM = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IF and MEM.
// Build option MEM_ARB_RR_EN: ties go to the requester not granted last;
// otherwise MEM wins every tie (fixed priority).
module mem_arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic eligible_if,
   input  logic eligible_mem,
`ifdef MEM_ARB_RR_EN
   input  logic last_grant,
`endif
   output logic grant_if,
   output logic grant_mem
);

   logic mem_wins_tie;

`ifdef MEM_ARB_RR_EN
   assign mem_wins_tie = (last_grant == GNT_IF);
`else
   assign mem_wins_tie = 1'b1;
`endif

   // One-hot winner: a lone requester always wins, a tie follows mem_wins_tie
   always_comb begin
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      if (eligible_if && eligible_mem) begin
         grant_mem = mem_wins_tie;
         grant_if  = ~mem_wins_tie;
      end else begin
         grant_if  = eligible_if;
         grant_mem = eligible_mem;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch (IF) and the data path
// (MEM). One registered RAM transaction at a time, completion pulses per
// requester, zero-bubble handoff when the other side is waiting, and a
// watchdog that aborts an access after WAIT_MAX cycles without ram_ready_i.
// Build option MEM_ARB_RR_EN selects round-robin tie breaking instead of
// fixed MEM priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_ce_i,
   input  logic [DATA_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_data_o,
   output logic              if_done_o,
   input  logic              mem_ce_i,
   input  logic              mem_we_i,
   input  logic [3:0]        mem_sel_i,
   input  logic [DATA_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              mem_done_o,
   output logic              ram_ce_o,
   output logic              ram_we_o,
   output logic [3:0]        ram_sel_o,
   output logic [DATA_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_data_o,
   input  logic [DATA_W-1:0] ram_data_i,
   input  logic              ram_ready_i,
   output logic              stallreq_if_o,
   output logic              stallreq_mem_o,
   output logic              err_o
);

   localparam int               CNT_W    = $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX);

   logic [1:0]       state;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_cnt_nxt;
   logic             elig_if;
   logic             elig_mem;
   logic             pick_if;
   logic             pick_mem;
   logic             busy;
   logic             timeout;
   logic             issue_if;
   logic             issue_mem;
   logic             go_idle;

   // A requester is never eligible in its own done cycle, so a held ce is
   // not mistaken for a new request.
   assign elig_if        = if_ce_i  & ~if_done_o;
   assign elig_mem       = mem_ce_i & ~mem_done_o;
   assign stallreq_if_o  = elig_if;
   assign stallreq_mem_o = elig_mem;

   assign busy         = (state == ARB_GRANT_IF) || (state == ARB_GRANT_MEM);
   assign wait_cnt_nxt = wait_cnt + CNT_W'(1);
   assign timeout      = busy && !ram_ready_i && (wait_cnt_nxt == CNT_LAST);

`ifdef MEM_ARB_RR_EN
   logic last_grant;

   // Remember who was granted most recently for round-robin tie breaking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           last_grant <= GNT_IF;
      else if (issue_if)  last_grant <= GNT_IF;
      else if (issue_mem) last_grant <= GNT_MEM;
   end
`endif

   mem_arb_pick u_pick (
      .eligible_if  (elig_if),
      .eligible_mem (elig_mem),
`ifdef MEM_ARB_RR_EN
      .last_grant   (last_grant),
`endif
      .grant_if     (pick_if),
      .grant_mem    (pick_mem)
   );

   // Decide the next RAM transaction: new grant from IDLE, handoff on ready,
   // or fall back to IDLE on ready-without-waiter or timeout
   always_comb begin
      issue_if  = 1'b0;
      issue_mem = 1'b0;
      go_idle   = 1'b0;
      case (state)
         ARB_IDLE: begin
            issue_if  = pick_if;
            issue_mem = pick_mem;
         end
         ARB_GRANT_IF: begin
            if (ram_ready_i) begin
               if (elig_mem) issue_mem = 1'b1;
               else          go_idle   = 1'b1;
            end else if (timeout) begin
               go_idle = 1'b1;
            end
         end
         ARB_GRANT_MEM: begin
            if (ram_ready_i) begin
               if (elig_if) issue_if = 1'b1;
               else         go_idle  = 1'b1;
            end else if (timeout) begin
               go_idle = 1'b1;
            end
         end
         default: go_idle = 1'b1;
      endcase
   end

   // Register the granted request onto the RAM port and track the wait count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ARB_IDLE;
         ram_ce_o   <= CHIP_DISABLE;
         ram_we_o   <= WRITE_DISABLE;
         ram_sel_o  <= '0;
         ram_addr_o <= '0;
         ram_data_o <= '0;
         wait_cnt   <= '0;
      end else if (issue_if) begin
         state      <= ARB_GRANT_IF;
         ram_ce_o   <= CHIP_ENABLE;
         ram_we_o   <= WRITE_DISABLE;
         ram_sel_o  <= SEL_ALL;
         ram_addr_o <= if_addr_i;
         ram_data_o <= '0;
         wait_cnt   <= '0;
      end else if (issue_mem) begin
         state      <= ARB_GRANT_MEM;
         ram_ce_o   <= CHIP_ENABLE;
         ram_we_o   <= mem_we_i;
         ram_sel_o  <= mem_sel_i;
         ram_addr_o <= mem_addr_i;
         ram_data_o <= mem_data_i;
         wait_cnt   <= '0;
      end else if (go_idle) begin
         state      <= ARB_IDLE;
         ram_ce_o   <= CHIP_DISABLE;
         ram_we_o   <= WRITE_DISABLE;
         wait_cnt   <= '0;
      end else if (busy) begin
         wait_cnt   <= wait_cnt_nxt;
      end
   end

   // Completion pulses, read-data capture and timeout error reporting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_done_o  <= 1'b0;
         mem_done_o <= 1'b0;
         err_o      <= 1'b0;
         if_data_o  <= '0;
         mem_data_o <= '0;
      end else begin
         if_done_o  <= (state == ARB_GRANT_IF)  && (ram_ready_i || timeout);
         mem_done_o <= (state == ARB_GRANT_MEM) && (ram_ready_i || timeout);
         err_o      <= timeout;
         if (state == ARB_GRANT_IF) begin
            if (timeout)                       if_data_o <= '0;
            else if (ram_ready_i && !ram_we_o) if_data_o <= ram_data_i;
         end
         if (state == ARB_GRANT_MEM) begin
            if (timeout)                       mem_data_o <= '0;
            else if (ram_ready_i && !ram_we_o) mem_data_o <= ram_data_i;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single IF read, IF/MEM tie with
// handoff, MEM write, timeout abort, asynchronous reset mid-access and
// back-to-back MEM reads.
module tb_mem_arbiter;

   localparam int DATA_W   = 32;
   localparam int WAIT_MAX = 15;

   logic              clk;
   logic              rst;
   logic              if_ce_i;
   logic [DATA_W-1:0] if_addr_i;
   logic [DATA_W-1:0] if_data_o;
   logic              if_done_o;
   logic              mem_ce_i;
   logic              mem_we_i;
   logic [3:0]        mem_sel_i;
   logic [DATA_W-1:0] mem_addr_i;
   logic [DATA_W-1:0] mem_data_i;
   logic [DATA_W-1:0] mem_data_o;
   logic              mem_done_o;
   logic              ram_ce_o;
   logic              ram_we_o;
   logic [3:0]        ram_sel_o;
   logic [DATA_W-1:0] ram_addr_o;
   logic [DATA_W-1:0] ram_data_o;
   logic [DATA_W-1:0] ram_data_i;
   logic              ram_ready_i;
   logic              stallreq_if_o;
   logic              stallreq_mem_o;
   logic              err_o;

   int n_cmp = 0;
   int n_bad = 0;

   mem_arbiter #(.DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)) dut (
      .clk            (clk),
      .rst            (rst),
      .if_ce_i        (if_ce_i),
      .if_addr_i      (if_addr_i),
      .if_data_o      (if_data_o),
      .if_done_o      (if_done_o),
      .mem_ce_i       (mem_ce_i),
      .mem_we_i       (mem_we_i),
      .mem_sel_i      (mem_sel_i),
      .mem_addr_i     (mem_addr_i),
      .mem_data_i     (mem_data_i),
      .mem_data_o     (mem_data_o),
      .mem_done_o     (mem_done_o),
      .ram_ce_o       (ram_ce_o),
      .ram_we_o       (ram_we_o),
      .ram_sel_o      (ram_sel_o),
      .ram_addr_o     (ram_addr_o),
      .ram_data_o     (ram_data_o),
      .ram_data_i     (ram_data_i),
      .ram_ready_i    (ram_ready_i),
      .stallreq_if_o  (stallreq_if_o),
      .stallreq_mem_o (stallreq_mem_o),
      .err_o          (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1);
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; if_ce_i = 1'b0; if_addr_i = '0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
      mem_sel_i = '0; mem_addr_i = '0; mem_data_i = '0; ram_data_i = '0; ram_ready_i = 1'b0;
      #3;
      n_cmp++; if (ram_ce_o !== 1'b0) begin n_bad++; $display("FAIL rst_ram_ce: got %b want 0", ram_ce_o); end
      n_cmp++; if ({ram_we_o, ram_sel_o, ram_addr_o, ram_data_o} !== '0) begin n_bad++; $display("FAIL rst_ram_bus: got nonzero want 0"); end
      n_cmp++; if ({if_done_o, mem_done_o, err_o} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses: got %b want 000", {if_done_o, mem_done_o, err_o}); end
      n_cmp++; if ({if_data_o, mem_data_o} !== '0) begin n_bad++; $display("FAIL rst_data: got %h/%h want 0/0", if_data_o, mem_data_o); end
      tick(); tick();
      #4 rst = 1'b1;
      tick();
      n_cmp++; if (ram_ce_o !== 1'b0) begin n_bad++; $display("FAIL rst_idle: got %b want 0", ram_ce_o); end
   endtask

   task automatic test_if_read();
      if_ce_i = 1'b1; if_addr_i = 32'h100;
      #1;
      n_cmp++; if (stallreq_if_o !== 1'b1) begin n_bad++; $display("FAIL t1_stall_req: got %b want 1", stallreq_if_o); end
      tick();
      n_cmp++; if (ram_ce_o !== 1'b1 || ram_addr_o !== 32'h100 || ram_we_o !== 1'b0) begin n_bad++; $display("FAIL t1_issue: got ce=%b addr=%h we=%b want 1/100/0", ram_ce_o, ram_addr_o, ram_we_o); end
      tick(); tick();
      ram_ready_i = 1'b1; ram_data_i = 32'hCAFE0001;
      n_cmp++; if (if_done_o !== 1'b0) begin n_bad++; $display("FAIL t1_early_done: got %b want 0", if_done_o); end
      tick();
      n_cmp++; if (if_done_o !== 1'b1 || if_data_o !== 32'hCAFE0001) begin n_bad++; $display("FAIL t1_done: got done=%b data=%h want 1/cafe0001", if_done_o, if_data_o); end
      n_cmp++; if (stallreq_if_o !== 1'b0) begin n_bad++; $display("FAIL t1_stall_done: got %b want 0", stallreq_if_o); end
      n_cmp++; if (ram_ce_o !== 1'b0) begin n_bad++; $display("FAIL t1_ce_drop: got %b want 0", ram_ce_o); end
      if_ce_i = 1'b0; ram_ready_i = 1'b0;
      tick();
      n_cmp++; if (if_done_o !== 1'b0) begin n_bad++; $display("FAIL t1_one_pulse: got %b want 0", if_done_o); end
   endtask

   task automatic test_tie();
      if_ce_i = 1'b1; if_addr_i = 32'h104;
      mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h40;
      tick();
      n_cmp++; if (ram_ce_o !== 1'b1 || ram_addr_o !== 32'h40) begin n_bad++; $display("FAIL t2_mem_first: got ce=%b addr=%h want 1/40", ram_ce_o, ram_addr_o); end
      n_cmp++; if (stallreq_if_o !== 1'b1 || stallreq_mem_o !== 1'b1) begin n_bad++; $display("FAIL t2_stalls: got %b%b want 11", stallreq_if_o, stallreq_mem_o); end
      ram_ready_i = 1'b1; ram_data_i = 32'h11112222;
      tick();
      n_cmp++; if (mem_done_o !== 1'b1 || mem_data_o !== 32'h11112222) begin n_bad++; $display("FAIL t2_mem_done: got done=%b data=%h want 1/11112222", mem_done_o, mem_data_o); end
      n_cmp++; if (ram_ce_o !== 1'b1 || ram_addr_o !== 32'h104) begin n_bad++; $display("FAIL t2_handoff: got ce=%b addr=%h want 1/104", ram_ce_o, ram_addr_o); end
      mem_ce_i = 1'b0; ram_data_i = 32'h33334444;
      tick();
      n_cmp++; if (if_done_o !== 1'b1 || if_data_o !== 32'h33334444 || mem_done_o !== 1'b0) begin n_bad++; $display("FAIL t2_if_done: got done=%b data=%h mdone=%b want 1/33334444/0", if_done_o, if_data_o, mem_done_o); end
      n_cmp++; if (ram_ce_o !== 1'b0) begin n_bad++; $display("FAIL t2_idle: got %b want 0", ram_ce_o); end
      if_ce_i = 1'b0; ram_ready_i = 1'b0;
      tick();
   endtask

   task automatic test_mem_write();
      mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011; mem_addr_i = 32'h20; mem_data_i = 32'hDEADBEEF;
      tick();
      n_cmp++; if (ram_ce_o !== 1'b1 || ram_we_o !== 1'b1 || ram_sel_o !== 4'b0011) begin n_bad++; $display("FAIL t3_ctrl: got ce=%b we=%b sel=%b want 1/1/0011", ram_ce_o, ram_we_o, ram_sel_o); end
      n_cmp++; if (ram_addr_o !== 32'h20 || ram_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL t3_bus: got addr=%h data=%h want 20/deadbeef", ram_addr_o, ram_data_o); end
      ram_ready_i = 1'b1; ram_data_i = 32'h55555555;
      tick();
      n_cmp++; if (mem_done_o !== 1'b1 || mem_data_o !== 32'h11112222) begin n_bad++; $display("FAIL t3_done: got done=%b data=%h want 1/11112222", mem_done_o, mem_data_o); end
      n_cmp++; if (ram_ce_o !== 1'b0 || ram_we_o !== 1'b0) begin n_bad++; $display("FAIL t3_idle: got ce=%b we=%b want 0/0", ram_ce_o, ram_we_o); end
      mem_ce_i = 1'b0; mem_we_i = 1'b0; ram_ready_i = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      if_ce_i = 1'b1; if_addr_i = 32'h200;
      tick();
      n_cmp++; if (ram_ce_o !== 1'b1 || ram_addr_o !== 32'h200) begin n_bad++; $display("FAIL t4_issue: got ce=%b addr=%h want 1/200", ram_ce_o, ram_addr_o); end
      for (int i = 0; i < WAIT_MAX - 1; i++) begin
         tick();
         if (ram_ce_o !== 1'b1 || err_o !== 1'b0 || if_done_o !== 1'b0) early++;
      end
      n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL t4_hold: got %0d bad busy cycles want 0", early); end
      tick();
      n_cmp++; if (err_o !== 1'b1 || if_done_o !== 1'b1) begin n_bad++; $display("FAIL t4_abort: got err=%b done=%b want 1/1", err_o, if_done_o); end
      n_cmp++; if (if_data_o !== 32'h0 || ram_ce_o !== 1'b0) begin n_bad++; $display("FAIL t4_clear: got data=%h ce=%b want 0/0", if_data_o, ram_ce_o); end
      if_ce_i = 1'b0;
      tick();
      n_cmp++; if (err_o !== 1'b0 || ram_ce_o !== 1'b0) begin n_bad++; $display("FAIL t4_pulse: got err=%b ce=%b want 0/0", err_o, ram_ce_o); end
   endtask

   task automatic test_async_reset();
      mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h80;
      tick();
      n_cmp++; if (ram_ce_o !== 1'b1) begin n_bad++; $display("FAIL t5_issue: got %b want 1", ram_ce_o); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (ram_ce_o !== 1'b0 || mem_done_o !== 1'b0) begin n_bad++; $display("FAIL t5_async: got ce=%b done=%b want 0/0", ram_ce_o, mem_done_o); end
      mem_ce_i = 1'b0;
      tick();
      #3 rst = 1'b1;
      tick();
      n_cmp++; if (ram_ce_o !== 1'b0 || mem_done_o !== 1'b0 || mem_data_o !== 32'h0) begin n_bad++; $display("FAIL t5_release: got ce=%b done=%b data=%h want 0/0/0", ram_ce_o, mem_done_o, mem_data_o); end
      mem_ce_i = 1'b1; mem_addr_i = 32'h84;
      tick();
      n_cmp++; if (ram_ce_o !== 1'b1 || ram_addr_o !== 32'h84) begin n_bad++; $display("FAIL t5_regrant: got ce=%b addr=%h want 1/84", ram_ce_o, ram_addr_o); end
      ram_ready_i = 1'b1; ram_data_i = 32'h0BADF00D;
      tick();
      mem_ce_i = 1'b0; ram_ready_i = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h0;
      ram_ready_i = 1'b1; ram_data_i = 32'hA0;
      tick();
      n_cmp++; if (ram_ce_o !== 1'b1 || ram_addr_o !== 32'h0) begin n_bad++; $display("FAIL t6_first: got ce=%b addr=%h want 1/0", ram_ce_o, ram_addr_o); end
      tick();
      n_cmp++; if (mem_done_o !== 1'b1 || mem_data_o !== 32'hA0 || ram_ce_o !== 1'b0) begin n_bad++; $display("FAIL t6_done1: got done=%b data=%h ce=%b want 1/a0/0", mem_done_o, mem_data_o, ram_ce_o); end
      mem_addr_i = 32'h4; ram_data_i = 32'hA4;
      tick();
      n_cmp++; if (ram_ce_o !== 1'b0 || mem_done_o !== 1'b0) begin n_bad++; $display("FAIL t6_no_regrant: got ce=%b done=%b want 0/0", ram_ce_o, mem_done_o); end
      tick();
      n_cmp++; if (ram_ce_o !== 1'b1 || ram_addr_o !== 32'h4) begin n_bad++; $display("FAIL t6_second: got ce=%b addr=%h want 1/4", ram_ce_o, ram_addr_o); end
      tick();
      n_cmp++; if (mem_done_o !== 1'b1 || mem_data_o !== 32'hA4) begin n_bad++; $display("FAIL t6_done2: got done=%b data=%h want 1/a4", mem_done_o, mem_data_o); end
      mem_ce_i = 1'b0; ram_ready_i = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_tie();
      test_mem_write();
      test_timeout();
      test_async_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
